button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Sits directly downstream of the button debouncer and consumes its debounced level `button_state`.
- Detects press and release edges and classifies each gesture as SHORT click, LONG press or DOUBLE click.
- Presents each classified gesture as a one-deep valid/ready event so that the APB register block or a controller FSM can pop it.

Parameters:
LONG_CYCLES, 50_000_000, clk cycles held in PRESS1 before LONG fires; must be >= 2
DCLICK_CYCLES, 12_500_000, max release gap (clk cycles) for a second press to form DOUBLE; must be >= 2
CNT_W, $clog2(max(LONG_CYCLES,DCLICK_CYCLES))+1, gesture counter width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
button_state  input  1  debounced button level, 1 = pressed
press_pulse  output  1  one-cycle pulse on debounced rising edge
release_pulse  output  1  one-cycle pulse on debounced falling edge
evt_valid  output  1  event register holds an unconsumed event
evt_code  output  2  01 SHORT, 10 LONG, 11 DOUBLE, 00 only when evt_valid=0
evt_ready  input  1  consumer accepts the event when evt_valid & evt_ready
evt_overflow  output  1  one-cycle pulse: new event dropped because the holding register was full
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: single clock; reset is synchronous, active-high, port `rst`. All outputs 0, FSM=IDLE, counter=0, btn_q=0.
- Edge detect: btn_q <= button_state each cycle. rise = button_state & ~btn_q; fall = ~button_state & btn_q. press_pulse/release_pulse are registered copies (1-cycle latency from the edge cycle).
- Counter cnt:
  - Cleared to 0 on every state transition.
  - Otherwise increments by 1 each cycle and saturates at all-ones.
  - Compares are ==, unsigned.
- FSM states and transitions:
  - IDLE: rise -> PRESS1.
  - PRESS1: fall -> WAIT2. Else cnt == LONG_CYCLES-1 -> emit LONG, go to HELD.
  - HELD: fall -> IDLE. No repeat events.
  - WAIT2: rise -> PRESS2. Else cnt == DCLICK_CYCLES-1 -> emit SHORT, go to IDLE.
  - PRESS2: fall -> emit DOUBLE, go to IDLE. No LONG classification in PRESS2; cnt saturates.
- Priority: edge tests take priority over timeout compares in the same cycle. A fall on the LONG-compare cycle goes to WAIT2 (no LONG); a rise on the SHORT-timeout cycle goes to PRESS2.
- Event register update (registered):
  - emit & (~evt_valid | evt_ready): load evt_code and set evt_valid=1 next cycle. This covers simultaneous pop and new event; no bubble.
  - emit & evt_valid & ~evt_ready: keep the old event, drop the new one, pulse evt_overflow for 1 cycle.
  - no emit & evt_valid & evt_ready: evt_valid=0, evt_code=00.
- Timing: LONG asserts evt_valid exactly LONG_CYCLES+1 cycles after the rise cycle. SHORT asserts DCLICK_CYCLES+1 cycles after the fall cycle.
- busy = (state != IDLE), combinational from the state register.
- rst mid-gesture: the gesture is abandoned with no event. If the button is still held when rst deasserts, btn_q=0 produces a rise on the first cycle and a new gesture starts. This is accepted.

Decomposition:
- Shared constants header, included by this block and the APB register block:
  - FSM state encodings: IDLE, PRESS1, HELD, WAIT2, PRESS2.
  - Event codes: EVT_NONE=2'b00, EVT_SHORT=2'b01, EVT_LONG=2'b10, EVT_DOUBLE=2'b11.
- One natural sub-module: event_hold_reg. It is the 1-deep valid/ready holding register with overflow pulse, and is reusable for other event sources.
- The FSM and counter stay in the top.

Test Plan (LONG_CYCLES=16, DCLICK_CYCLES=8, evt_ready=1 unless stated):
- Press 5 cycles, release, idle 20 -> press_pulse and release_pulse 1 cycle each; single SHORT (01) valid 9 cycles after the fall cycle; busy back to 0.
- Press 30 cycles -> LONG (10) valid 17 cycles after the rise cycle; release gives release_pulse only, no second event.
- Press 4, gap 3, press 4, release -> single DOUBLE (11) 1 cycle after the second fall; no SHORT emitted.
- Boundaries:
  - Fall on the exact cycle cnt==15 in PRESS1 -> no LONG; a SHORT follows.
  - Rise on the exact cycle cnt==7 in WAIT2 -> DOUBLE, not SHORT.
- evt_ready=0, two SHORT gestures -> first event held with code 01; second dropped with a 1-cycle evt_overflow. Then raise evt_ready for 1 cycle -> evt_valid=0 and evt_code=00.
- Assert rst during PRESS1 while holding the button -> all outputs 0 the next cycle; after release of rst a new rise is seen, and the LONG count restarts from 0.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - gesture FSM state encodings and event codes
// Shared by the gesture decoder and the register block that reads its events.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HELD   = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_PRESS2 = 3'd4
  } state_e;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_event_hold_reg.sv
// rtl/button_event_decoder_event_hold_reg.sv - one-deep valid/ready event holding register
// A new event arriving while an unpopped one is held is dropped and flagged for one cycle.
module event_hold_reg
  import button_event_decoder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       emit_i,
  input  logic [1:0] code_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [1:0] code_o,
  output logic       overflow_o
);

  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       overflow_q, overflow_d;

  always_comb begin
    valid_d    = valid_q;
    code_d     = code_q;
    overflow_d = 1'b0;
    if (emit_i && (!valid_q || ready_i)) begin
      // Pop and load in the same cycle leaves no bubble.
      valid_d = 1'b1;
      code_d  = code_i;
    end else if (emit_i) begin
      overflow_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      code_d  = EVT_NONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      code_q     <= EVT_NONE;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = valid_q;
  assign code_o     = code_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies debounced button gestures as SHORT, LONG or DOUBLE
// Edge detector, gesture FSM and shared cycle counter; events leave through event_hold_reg.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned DCLICK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_CYCLES, DCLICK_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_q, release_q;
  logic             rise, fall;
  logic             emit;
  logic [1:0]       emit_code;

  assign rise = button_state & ~btn_q;
  assign fall = ~button_state & btn_q;

  // Edge tests are checked before the timeout compares in every state.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_d   = ST_HELD;
        end
      end
      ST_HELD: begin
        if (fall) state_d = ST_IDLE;
      end
      ST_WAIT2: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == DCLICK_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          state_d   = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= button_state;
      press_q   <= rise;
      release_q <= fall;
    end
  end

  event_hold_reg u_hold (
    .clk_i      (clk),
    .rst_i      (rst),
    .emit_i     (emit),
    .code_i     (emit_code),
    .ready_i    (evt_ready),
    .valid_o    (evt_valid),
    .code_o     (evt_code),
    .overflow_o (evt_overflow)
  );

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
